watch_fnd_ctrl: RTL and testbench
=================================

Name: watch_fnd_ctrl

Overview:
- Display stage directly downstream of the watch datapath.
- Takes the hour/min/sec/msec counts and drives a 4-digit common-anode 7-segment display with time-multiplexed scanning.
- Selects the sec:msec or hour:min page, blinks the field under edit, and blinks the centre dot at 1 Hz.
- Snapshots the counts once per scan frame, so a digit pair is never torn mid-frame.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- SCAN_HZ, 1000, per-digit scan rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit.
- BLINK_HZ, 2, edit blink rate; phase toggles every BLINK_DIV = CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sel_display  in  1  page select: 1 = hour:min, 0 = sec:msec
- edit_en  in  1  1 = edit mode; blinking is enabled
- edit_digit  in  4  one-hot field under edit: [0] msec, [1] sec, [2] min, [3] hour
- msec  in  7  0..99
- sec  in  6  0..59
- min  in  6  0..59
- hour  in  5  0..23
- fnd_com  out  4  digit enables, active-low; [0] = rightmost digit
- fnd_data  out  8  segments, active-low; [6:0] = g..a, [7] = dp

Behaviour:
- Reset (reset=0, async):
  - scan counter = 0, digit index idx = 3, started = 0.
  - All snapshots = 0, blink counter = 0, blink phase = visible.
  - fnd_com = 4'b1111, fnd_data = 8'hFF.
- Scan tick: asserted for 1 cycle when the scan counter reaches SCAN_DIV-1, then the counter wraps to 0. On each tick, idx <= (idx+1) mod 4 and started <= 1.
- Snapshot: on the tick that moves idx 3->0, the current msec/sec/min/hour and sel_display are copied into snapshot registers. The first tick after reset is such a tick. Inputs are otherwise ignored until the next frame boundary.
- Outputs are registered with 1-cycle latency.
  - fnd_com and fnd_data change on the cycle after idx changes.
  - While started=0, the outputs hold their reset values.
  - fnd_com = ~(4'b0001 << idx).
- Page (from snapshot):
  - sel=0: digit3/2 = sec tens/ones, digit1/0 = msec tens/ones.
  - sel=1: digit3/2 = hour tens/ones, digit1/0 = min tens/ones.
  - Leading zeros are shown (hour 5 displays "05").
- BCD: tens = v/10, ones = v%10.
  - Segment codes 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (bit7=1).
  - Out-of-range value (msec>99, sec/min>59, hour>23): both digits of that field show dash 8'hBF.
- Dot: fnd_data[7] = 0 on digit2 only, and only when snapshot msec < 50. This applies on both pages. All other digits have dp = 1.
- Blink:
  - While edit_en=1, the blink counter runs and the phase toggles every BLINK_DIV cycles.
  - When edit_en=0, the counter is held at 0 and the phase is forced to visible. A rising edge of edit_en therefore always starts in the visible phase.
  - In the hidden phase, both digits of the selected field show 8'hFF (dp also off), but only if that field belongs to the current snapshot page. Selecting a field on the other page causes no blanking.
  - edit_digit = 0 or multi-hot: blank every selected field on the current page.
- Simultaneous events: a scan tick and a blink toggle in the same cycle are independent; both take effect. edit_en and edit_digit are sampled live, not snapshotted.
- Reset mid-frame: all state returns to reset values immediately, and the display blanks until the first tick.

Test Plan:
- Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), BLINK_HZ=10 (BLINK_DIV=50).
- Reset release: fnd_com=1111 and fnd_data=FF for 10 cycles. After the first tick, fnd_com=1110 one cycle later, and the sequence continues 1101, 1011, 0111, 1110 every 10 cycles.
- sel=0, sec=37, msec=42: digits 3..0 = B0, F8, 99, A4. Digit2 dp is 0, so digit2 shows 78.
- sel=1, hour=9, min=5: digits 3..0 = C0, 90, C0, 92. Then set msec=75: digit2 shows 90 with dp=1.
- Tearing: change min 5->6 while idx=1. Digits 1/0 keep showing "05" until the next 3->0 tick, then show "06".
- edit_en=1, edit_digit=0100, sel=1: digits 1/0 are visible for 50 cycles, then FF for 50 cycles, repeating. Digits 3/2 never blank. Switch to sel=0: no digit blanks.
- msec=120, sel=0: digits 1/0 = BF, BF. Assert reset mid-frame: outputs go to 1111/FF immediately.

Source files
------------

// File: rtl/watch_fnd_ctrl.sv
// Drives a 4-digit common-anode 7-segment display from the watch counts.
// Counts are snapshotted once per scan frame; the edit field blinks and the centre dot marks msec < 50.
module watch_fnd_ctrl #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_display,
  input  logic       edit_en,
  input  logic [3:0] edit_digit,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic               scan_tick_s;
  logic [1:0]         idx_r;
  logic               started_r;

  logic [6:0]         snap_msec_r;
  logic [5:0]         snap_sec_r;
  logic [5:0]         snap_min_r;
  logic [4:0]         snap_hour_r;
  logic               snap_sel_r;

  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_hidden_r;

  logic [6:0]         field_val_s;
  logic [6:0]         field_max_s;
  logic               field_edit_s;
  logic [6:0]         tens_s;
  logic [6:0]         ones_s;
  logic [7:0]         data_s;

  function automatic logic [7:0] seg_code(input logic [6:0] d);
    logic [7:0] code;
    case (d)
      7'd0:    code = 8'hC0;
      7'd1:    code = 8'hF9;
      7'd2:    code = 8'hA4;
      7'd3:    code = 8'hB0;
      7'd4:    code = 8'h99;
      7'd5:    code = 8'h92;
      7'd6:    code = 8'h82;
      7'd7:    code = 8'hF8;
      7'd8:    code = 8'h80;
      7'd9:    code = 8'h90;
      default: code = 8'hBF;
    endcase
    return code;
  endfunction

  assign scan_tick_s = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));

  // Per-digit scan timer and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= 2'd3;
      started_r  <= 1'b0;
    end else if (scan_tick_s) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= idx_r + 2'd1;
      started_r  <= 1'b1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Frame snapshot, taken on the tick that wraps the index back to digit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_msec_r <= 7'd0;
      snap_sec_r  <= 6'd0;
      snap_min_r  <= 6'd0;
      snap_hour_r <= 5'd0;
      snap_sel_r  <= 1'b0;
    end else if (scan_tick_s && (idx_r == 2'd3)) begin
      snap_msec_r <= msec;
      snap_sec_r  <= sec;
      snap_min_r  <= min;
      snap_hour_r <= hour;
      snap_sel_r  <= sel_display;
    end
  end

  // Edit blink timer; parked in the visible phase whenever editing is off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_r    <= {BLINK_W{1'b0}};
      blink_hidden_r <= 1'b0;
    end else if (!edit_en) begin
      blink_cnt_r    <= {BLINK_W{1'b0}};
      blink_hidden_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_r    <= {BLINK_W{1'b0}};
      blink_hidden_r <= ~blink_hidden_r;
    end else begin
      blink_cnt_r    <= blink_cnt_r + BLINK_W'(1);
    end
  end

  // Pick the field feeding the current digit pair on the snapshot page
  always_comb begin
    field_val_s  = 7'd0;
    field_max_s  = 7'd0;
    field_edit_s = 1'b0;
    case ({snap_sel_r, idx_r[1]})
      2'b00: begin
        field_val_s  = snap_msec_r;
        field_max_s  = 7'd99;
        field_edit_s = edit_digit[0];
      end
      2'b01: begin
        field_val_s  = {1'b0, snap_sec_r};
        field_max_s  = 7'd59;
        field_edit_s = edit_digit[1];
      end
      2'b10: begin
        field_val_s  = {1'b0, snap_min_r};
        field_max_s  = 7'd59;
        field_edit_s = edit_digit[2];
      end
      2'b11: begin
        field_val_s  = {2'b00, snap_hour_r};
        field_max_s  = 7'd23;
        field_edit_s = edit_digit[3];
      end
      default: begin
        field_val_s  = 7'd0;
        field_max_s  = 7'd0;
        field_edit_s = 1'b0;
      end
    endcase
  end

  assign tens_s = field_val_s / 7'd10;
  assign ones_s = field_val_s % 7'd10;

  // Segment pattern: blanking beats the range dash, which beats the digit code
  always_comb begin
    data_s = 8'hFF;
    if (edit_en && blink_hidden_r && field_edit_s) begin
      data_s = 8'hFF;
    end else if (field_val_s > field_max_s) begin
      data_s = 8'hBF;
    end else begin
      data_s = seg_code(idx_r[0] ? tens_s : ones_s);
      if ((idx_r == 2'd2) && (snap_msec_r < 7'd50)) begin
        data_s[7] = 1'b0;
      end else begin
        data_s[7] = 1'b1;
      end
    end
  end

  // Registered display outputs, dark until the first scan tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end else if (started_r) begin
      fnd_com  <= ~(4'b0001 << idx_r);
      fnd_data <= data_s;
    end else begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_watch_fnd_ctrl.sv
// Directed plus randomized bench for watch_fnd_ctrl against a cycle-count based reference model.
module tb_watch_fnd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel_display;
  logic       edit_en;
  logic [3:0] edit_digit;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int total  = 0;
  int passed = 0;

  // model state: edges since reset release, snapshot, edges edit_en has been held high
  int         m_n;
  int         m_r;
  int         m_msec, m_sec, m_min, m_hour;
  logic       m_sel;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  watch_fnd_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10)) dut (
    .clk(clk), .reset(reset), .sel_display(sel_display), .edit_en(edit_en),
    .edit_digit(edit_digit), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_n = 0; m_r = 0;
    m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0; m_sel = 1'b0;
  endtask

  // Expected registered output produced by the coming edge, from pre-edge model state
  task automatic model_out(output logic [3:0] ec, output logic [7:0] ed);
    int t, d, v, maxv, fbit, dig;
    ec = 4'b1111; ed = 8'hFF;
    t = m_n / 10;
    if (reset && t > 0) begin
      d = (3 + t) % 4;
      ec[d] = 1'b0;
      if (d >= 2) begin
        if (m_sel) begin v = m_hour; maxv = 23; fbit = 3; end
        else       begin v = m_sec;  maxv = 59; fbit = 1; end
      end else begin
        if (m_sel) begin v = m_min;  maxv = 59; fbit = 2; end
        else       begin v = m_msec; maxv = 99; fbit = 0; end
      end
      dig = (d % 2 == 1) ? v / 10 : v % 10;
      if (edit_en && ((m_r / 50) % 2 == 1) && edit_digit[fbit]) ed = 8'hFF;
      else if (v > maxv) ed = 8'hBF;
      else begin
        ed = seg_tab[dig];
        if (d == 2 && m_msec < 50) ed[7] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    if (!reset) model_clear();
    else begin
      m_n++;
      if (m_n % 40 == 10) begin
        m_msec = msec; m_sec = sec; m_min = min; m_hour = hour; m_sel = sel_display;
      end
      m_r = edit_en ? m_r + 1 : 0;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] ec, input logic [7:0] ed);
    total++;
    assert (fnd_com === ec) passed++;
    else $error("FAIL %s com n=%0d observed %b expected %b", tag, m_n, fnd_com, ec);
    total++;
    assert (fnd_data === ed) passed++;
    else $error("FAIL %s data n=%0d observed %h expected %h", tag, m_n, fnd_data, ed);
  endtask

  task automatic step(input string tag = "scan");
    logic [3:0] ec;
    logic [7:0] ed;
    @(posedge clk);
    model_out(ec, ed);
    #1;
    check(tag, ec, ed);
    model_update();
  endtask

  // Advance until the model has just taken a frame snapshot
  task automatic run_frame();
    for (int i = 0; i < 45; i++) begin
      step();
      if (m_n % 40 == 10) break;
    end
  endtask

  task automatic expect_digit(input int d, input logic [7:0] v, input string tag);
    logic [3:0] want;
    bit found;
    want = 4'b1111;
    want[d] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (fnd_com === want) found = 1'b1;
    end
    total++;
    assert (found && fnd_data === v) passed++;
    else $error("FAIL %s digit%0d observed %h (seen=%0d) expected %h", tag, d, fnd_data, found, v);
  endtask

  task automatic async_reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    model_clear();
    check(tag, 4'b1111, 8'hFF);
    step(tag);
    step(tag);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; sel_display = 1'b0; edit_en = 1'b0; edit_digit = 4'b0000;
    msec = 7'd42; sec = 6'd37; min = 6'd5; hour = 5'd9;
    model_clear();
    step("reset"); step("reset"); step("reset");
    reset = 1'b1;

    // first frame: sec:msec page, 37:42
    run_frame();
    expect_digit(0, 8'hA4, "sec_msec");
    expect_digit(1, 8'h99, "sec_msec");
    expect_digit(2, 8'h78, "sec_msec_dp");
    expect_digit(3, 8'hB0, "sec_msec");

    // hour:min page, 09:05
    sel_display = 1'b1;
    run_frame();
    expect_digit(0, 8'h92, "hour_min");
    expect_digit(1, 8'hC0, "hour_min");
    expect_digit(2, 8'h10, "hour_min_dp");
    expect_digit(3, 8'hC0, "hour_min");
    msec = 7'd75;
    run_frame();
    expect_digit(2, 8'h90, "dp_off");

    // tearing: min changes while digit1 is lit
    run_frame();
    expect_digit(1, 8'hC0, "tear_before");
    min = 6'd6;
    expect_digit(0, 8'h82, "tear_after");
    expect_digit(1, 8'hC0, "tear_after");

    // blink the minute field, then flip to the other page
    edit_en = 1'b1; edit_digit = 4'b0100;
    for (int i = 0; i < 220; i++) step("blink_min");
    sel_display = 1'b0;
    for (int i = 0; i < 120; i++) step("blink_other_page");
    edit_en = 1'b0;

    // out-of-range msec shows dashes, then reset lands mid-frame
    msec = 7'd120;
    run_frame();
    expect_digit(0, 8'hBF, "dash");
    expect_digit(1, 8'hBF, "dash");
    step(); step(); step();
    async_reset_pulse("mid_reset");
    for (int i = 0; i < 15; i++) step("after_reset");

    // randomized inputs, page and edit activity
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        msec = 7'($urandom_range(0, 127));
        sec  = 6'($urandom_range(0, 59));
        min  = 6'($urandom_range(0, 59));
        hour = 5'($urandom_range(0, 23));
        sel_display = 1'($urandom_range(0, 1));
        edit_digit  = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 149) == 0) edit_en = ~edit_en;
      if (i == 700) async_reset_pulse("rand_reset");
      step("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
